// File: rtl/instr_mem_responder.sv
// instr_mem_responder
//   Memory end of the instruction fetch req/grant/rvalid protocol. It grants
//   requests after GNT_LATENCY cycles of instr_req, captures the addressed
//   word at grant time into a small in-order response FIFO, and returns each
//   word RVALID_LATENCY cycles after its grant. A preload port writes the
//   word array at any time, including during reset.
//
//   Handshake: the requester raises instr_req with a stable instr_addr and
//   holds both until the cycle in which instr_grant is high. That cycle
//   transfers the request. Every grant produces exactly one instr_rvalid
//   pulse later, in grant order, which cannot be back-pressured. Reset
//   discards all granted but unanswered requests.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     instr_req/addr    fetch request and byte address (word = addr[..:2])
//     instr_grant       request accepted this cycle
//     instr_rvalid      instr_rdata valid this cycle
//     instr_rdata       returned word, holds last value while rvalid is low
//     load_we/addr/data preload write port into the word array
//     outstanding       granted but unanswered request count
//     gnt_state_dbg     grant FSM state (0 = G_IDLE, 1 = G_WAIT)
//
//   Optional build macro: INSTR_MEM_STALL_EN adds LFSR-driven random grant
//   stalls. Without it grant timing is fully deterministic.
module instr_mem_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_WORDS      = 1024,
  parameter int GNT_LATENCY    = 0,
  parameter int RVALID_LATENCY = 1,
  parameter int DEPTH          = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_req,
  input  logic [ADDR_WIDTH-1:0]        instr_addr,
  output logic                         instr_grant,
  output logic                         instr_rvalid,
  output logic [DATA_WIDTH-1:0]        instr_rdata,
  input  logic                         load_we,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         gnt_state_dbg
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    G_IDLE = 1'b0,
    G_WAIT = 1'b1
  } gnt_state_e;

  gnt_state_e            state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [3:0]            age_q [DEPTH];
  logic [3:0]            age_d [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic [IDX_W-1:0]      req_idx;
  logic [CNT_W-1:0]      wr_idx;
  logic                  stall;
  logic                  wait_ok;
  logic                  grant;
  logic                  pop;
  logic                  unused_addr;

  function automatic logic [3:0] age_inc(input logic [3:0] a);
    return (a == 4'hF) ? a : a + 4'd1;
  endfunction

  // Word index; bits above the array depth are dropped so addresses wrap.
  assign req_idx     = instr_addr[IDX_W+1:2];
  assign unused_addr = ^instr_addr;

`ifdef INSTR_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Comparisons written as (x + 1 > N) so a latency of 0 does not become a
  // constant-true unsigned compare.
  assign wait_ok = ({1'b0, wait_cnt_q} + 5'd1) > 5'(GNT_LATENCY);

  // A full FIFO withholds grant even if the head pops this cycle.
  assign grant = !rst && instr_req && !stall && wait_ok && (count_q < DEPTH_C);

  // Head entry has age k-1 in the k-th cycle after its grant, so this fires
  // exactly RVALID_LATENCY cycles after the grant.
  assign pop = !rst && (count_q != '0) &&
               (({1'b0, age_q[0]} + 5'd1) > 5'(RVALID_LATENCY - 1));

  assign instr_grant   = grant;
  assign instr_rvalid  = pop;
  assign instr_rdata   = pop ? data_q[0] : rdata_q;
  assign outstanding   = count_q;
  assign gnt_state_dbg = state_q;

  // Grant FSM. wait_cnt counts every cycle the request is pending, including
  // the cycle it first rises, so grant lands GNT_LATENCY cycles after req.
  // A dropped request (protocol violation) simply restarts the count.
  always_comb begin
    state_d    = G_IDLE;
    wait_cnt_d = 4'd0;
    if (instr_req && !grant) begin
      state_d    = G_WAIT;
      wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  // Response FIFO as a shift register: head at index 0.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
      age_d[i]  = age_inc(age_q[i]);
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
        age_d[i]  = age_inc(age_q[i+1]);
      end
      data_d[DEPTH-1] = '0;
      age_d[DEPTH-1]  = 4'd0;
    end
    wr_idx = count_q - CNT_W'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (grant && (CNT_W'(i) == wr_idx)) begin
        data_d[i] = mem_q[req_idx];
        age_d[i]  = 4'd0;
      end
    end
    count_d = count_q + CNT_W'(grant) - CNT_W'(pop);
    rdata_d = pop ? data_q[0] : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= G_IDLE;
      wait_cnt_q <= 4'd0;
      count_q    <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        age_q[i]  <= 4'd0;
      end
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  // Word array is not reset; preload works during reset as well. A grant
  // in the same cycle reads the value from before this write.
  always_ff @(posedge clk) begin
    if (load_we) mem_q[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;

  localparam int NI = 4;

  // Instance configurations: 0 (G0,R1,D2) 1 (G3,R2,D2) 2 (G0,R4,D2) 3 (G1,R3,D3)
  function automatic int gl_of(input int i);
    case (i)
      1:       return 3;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int rl_of(input int i);
    case (i)
      1:       return 2;
      2:       return 4;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int dp_of(input int i);
    return (i == 3) ? 3 : 2;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req   [NI];
  logic [31:0] addr  [NI];
  logic        we    [NI];
  logic [3:0]  la    [NI];
  logic [31:0] ld    [NI];
  logic        gnt   [NI];
  logic        rv    [NI];
  logic [31:0] rd    [NI];
  logic [1:0]  outst [NI];
  logic        dbg   [NI];

  for (genvar i = 0; i < NI; i++) begin : g_dut
    instr_mem_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(16),
      .GNT_LATENCY(gl_of(i)), .RVALID_LATENCY(rl_of(i)), .DEPTH(dp_of(i))
    ) u_dut (
      .clk(clk), .rst(rst),
      .instr_req(req[i]), .instr_addr(addr[i]),
      .instr_grant(gnt[i]), .instr_rvalid(rv[i]), .instr_rdata(rd[i]),
      .load_we(we[i]), .load_addr(la[i]), .load_data(ld[i]),
      .outstanding(outst[i]), .gnt_state_dbg(dbg[i])
    );
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] mem_m   [NI][16];
  logic [31:0] last_rd [NI];
  logic [31:0] exp_q[$];
  int          due_q[$];

  typedef struct {
    int k; bit r; bit q; logic [31:0] a; bit w; logic [3:0] l; logic [31:0] d;
    bit eg; bit erv; logic [31:0] erd; logic [1:0] eo; bit cd;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; addr[i] = '0; we[i] = 1'b0; la[i] = '0; ld[i] = '0;
    end
  endtask

  task automatic add(input int k, input bit r, input bit q, input logic [31:0] a,
                     input bit w, input logic [3:0] l, input logic [31:0] d,
                     input bit eg, input bit erv, input logic [31:0] erd,
                     input logic [1:0] eo, input bit cd);
    vec_t v;
    v.k = k; v.r = r; v.q = q; v.a = a; v.w = w; v.l = l; v.d = d;
    v.eg = eg; v.erv = erv; v.erd = erd; v.eo = eo; v.cd = cd;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] init_word(input int j);
    return (j == 4) ? 32'h0000_0013 : 32'h1000_0000 + 32'(j);
  endfunction

  task automatic apply_vectors();
    foreach (vecs[j]) begin
      @(posedge clk); #1;
      idle_all();
      rst = vecs[j].r;
      req[vecs[j].k]  = vecs[j].q;
      addr[vecs[j].k] = vecs[j].a;
      we[vecs[j].k]   = vecs[j].w;
      la[vecs[j].k]   = vecs[j].l;
      ld[vecs[j].k]   = vecs[j].d;
      @(negedge clk);
      check("vec_grant",  vecs[j].k, {31'b0, gnt[vecs[j].k]}, {31'b0, vecs[j].eg});
      check("vec_rvalid", vecs[j].k, {31'b0, rv[vecs[j].k]},  {31'b0, vecs[j].erv});
      if (vecs[j].cd) begin
        check("vec_rdata", vecs[j].k, rd[vecs[j].k], vecs[j].erd);
        check("vec_outstanding", vecs[j].k, {30'b0, outst[vecs[j].k]}, {30'b0, vecs[j].eo});
        last_rd[vecs[j].k] = vecs[j].erd;
      end
      if (vecs[j].w) mem_m[vecs[j].k][vecs[j].l] = vecs[j].d;
      if (vecs[j].r) for (int i = 0; i < NI; i++) last_rd[i] = '0;
      cyc++;
    end
  endtask

  // Randomized traffic on one instance against a timestamp-based model:
  // a request may be granted once it has been pending GNT_LATENCY cycles and
  // fewer than DEPTH earlier grants are still unanswered; each grant's word
  // is due exactly RVALID_LATENCY cycles later, in order.
  task automatic run_random(input int k, input int ncyc);
    bit          hold = 1'b0;
    int          start = 0;
    logic [31:0] held_addr = '0;
    int          occ;
    bit          e_gnt, e_rv;
    logic [31:0] e_rd;
    exp_q.delete(); due_q.delete();
    for (int c = 0; c < ncyc + 40; c++) begin
      @(posedge clk); #1;
      idle_all();
      rst = 1'b0;
      if (!hold) begin
        hold = (c < ncyc) && ($urandom_range(0, 99) < 60);
        held_addr = $urandom;
        start = cyc;
      end
      req[k]  = hold;
      addr[k] = held_addr;
      if (c < ncyc) begin
        we[k] = ($urandom_range(0, 3) == 0);
        la[k] = 4'($urandom_range(0, 15));
        ld[k] = $urandom;
        rst   = ($urandom_range(0, 149) == 0);
      end
      @(negedge clk);
      occ   = exp_q.size();
      e_rv  = !rst && (occ > 0) && (due_q[0] == cyc);
      e_gnt = !rst && hold && ((cyc - start) >= gl_of(k)) && (occ < dp_of(k));
      e_rd  = e_rv ? exp_q[0] : last_rd[k];
      check("rnd_grant",  k, {31'b0, gnt[k]}, {31'b0, e_gnt});
      check("rnd_rvalid", k, {31'b0, rv[k]},  {31'b0, e_rv});
      if (!rst) begin
        check("rnd_rdata", k, rd[k], e_rd);
        check("rnd_outstanding", k, {30'b0, outst[k]}, 32'(occ));
      end
      if (e_rv) begin
        last_rd[k] = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      if (e_gnt) begin
        exp_q.push_back(mem_m[k][held_addr[5:2]]);
        due_q.push_back(cyc + rl_of(k));
        hold = 1'b0;
      end
      if (we[k]) mem_m[k][la[k]] = ld[k];
      if (rst) begin
        hold = 1'b0;
        exp_q.delete(); due_q.delete();
        for (int i = 0; i < NI; i++) last_rd[i] = '0;
      end
      cyc++;
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    idle_all();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) last_rd[i] = '0;

    // Preload while in reset.
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        we[i] = 1'b1; la[i] = 4'(j); ld[i] = init_word(j);
        mem_m[i][j] = init_word(j);
      end
    end

    // Grant forced low while in reset, then reset values on every instance.
    add(0, 1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NI; i++) add(i, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'd0, 1);

    // inst0 (G0,R1,D2): basic fetch, wrap, same-cycle load, back-to-back.
    add(0, 0, 1, 32'h10, 0, 0, 0,            1, 0, 32'h0,         2'd0, 1);
    add(0, 0, 0, 0,      0, 0, 0,            0, 1, 32'h13,        2'd1, 1);
    add(0, 0, 0, 0,      0, 0, 0,            0, 0, 32'h13,        2'd0, 1);
    add(0, 0, 1, 32'h48, 0, 0, 0,            1, 0, 32'h13,        2'd0, 1);
    add(0, 0, 0, 0,      0, 0, 0,            0, 1, 32'h1000_0002, 2'd1, 1);
    add(0, 0, 1, 32'h14, 1, 5, 32'hDEADBEEF, 1, 0, 32'h1000_0002, 2'd0, 1);
    add(0, 0, 1, 32'h14, 0, 0, 0,            1, 1, 32'h1000_0005, 2'd1, 1);
    add(0, 0, 0, 0,      0, 0, 0,            0, 1, 32'hDEADBEEF,  2'd1, 1);
    add(0, 0, 0, 0,      0, 0, 0,            0, 0, 32'hDEADBEEF,  2'd0, 1);
    add(0, 0, 1, 32'h0,  0, 0, 0,            1, 0, 32'hDEADBEEF,  2'd0, 1);
    add(0, 0, 1, 32'h4,  0, 0, 0,            1, 1, 32'h1000_0000, 2'd1, 1);
    add(0, 0, 1, 32'h8,  0, 0, 0,            1, 1, 32'h1000_0001, 2'd1, 1);
    add(0, 0, 0, 0,      0, 0, 0,            0, 1, 32'h1000_0002, 2'd1, 1);
    add(0, 0, 0, 0,      0, 0, 0,            0, 0, 32'h1000_0002, 2'd0, 1);

    // inst1 (G3,R2,D2): grant latency, then a dropped request restarts it.
    for (int j = 0; j < 3; j++) add(1, 0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h0, 2'd0, 1);
    add(1, 0, 1, 32'h10, 0, 0, 0, 1, 0, 32'h0,  2'd0, 1);
    add(1, 0, 0, 0,      0, 0, 0, 0, 0, 32'h0,  2'd1, 1);
    add(1, 0, 0, 0,      0, 0, 0, 0, 1, 32'h13, 2'd1, 1);
    add(1, 0, 0, 0,      0, 0, 0, 0, 0, 32'h13, 2'd0, 1);
    add(1, 0, 1, 32'h0,  0, 0, 0, 0, 0, 32'h13, 2'd0, 1);
    add(1, 0, 0, 0,      0, 0, 0, 0, 0, 32'h13, 2'd0, 1);
    for (int j = 0; j < 3; j++) add(1, 0, 1, 32'h4, 0, 0, 0, 0, 0, 32'h13, 2'd0, 1);
    add(1, 0, 1, 32'h4,  0, 0, 0, 1, 0, 32'h13,        2'd0, 1);
    add(1, 0, 0, 0,      0, 0, 0, 0, 0, 32'h13,        2'd1, 1);
    add(1, 0, 0, 0,      0, 0, 0, 0, 1, 32'h1000_0001, 2'd1, 1);
    add(1, 0, 0, 0,      0, 0, 0, 0, 0, 32'h1000_0001, 2'd0, 1);

    // inst2 (G0,R4,D2): full FIFO withholds the third grant.
    add(2, 0, 1, 32'h0, 0, 0, 0, 1, 0, 32'h0,         2'd0, 1);
    add(2, 0, 1, 32'h4, 0, 0, 0, 1, 0, 32'h0,         2'd1, 1);
    add(2, 0, 1, 32'h8, 0, 0, 0, 0, 0, 32'h0,         2'd2, 1);
    add(2, 0, 1, 32'h8, 0, 0, 0, 0, 0, 32'h0,         2'd2, 1);
    add(2, 0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h1000_0000, 2'd2, 1);
    add(2, 0, 1, 32'h8, 0, 0, 0, 1, 1, 32'h1000_0001, 2'd1, 1);
    for (int j = 0; j < 3; j++) add(2, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000_0001, 2'd1, 1);
    add(2, 0, 0, 0,     0, 0, 0, 0, 1, 32'h1000_0002, 2'd1, 1);
    add(2, 0, 0, 0,     0, 0, 0, 0, 0, 32'h1000_0002, 2'd0, 1);

    // inst3 (G1,R3,D3): reset one cycle after a grant flushes it.
    add(3, 0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h0, 2'd0, 1);
    add(3, 0, 1, 32'h10, 0, 0, 0, 1, 0, 32'h0, 2'd0, 1);
    add(3, 1, 0, 0,      0, 0, 0, 0, 0, 32'h0, 2'd0, 0);
    for (int j = 0; j < 4; j++) add(3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'd0, 1);
    add(3, 0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h0,  2'd0, 1);
    add(3, 0, 1, 32'h10, 0, 0, 0, 1, 0, 32'h0,  2'd0, 1);
    add(3, 0, 0, 0,      0, 0, 0, 0, 0, 32'h0,  2'd1, 1);
    add(3, 0, 0, 0,      0, 0, 0, 0, 0, 32'h0,  2'd1, 1);
    add(3, 0, 0, 0,      0, 0, 0, 0, 1, 32'h13, 2'd1, 1);
    add(3, 0, 0, 0,      0, 0, 0, 0, 0, 32'h13, 2'd0, 1);

    apply_vectors();

    for (int k = 0; k < NI; k++) run_random(k, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Synthesisable responder for the core's instruction memory port, the memory end of the req/grant/rvalid fetch protocol. It accepts fetch requests, grants them after a configurable delay, and returns instruction words in order after a configurable response latency. It sits between the core's IF stage and a preloadable word array. Its varied latencies give the IF trace logic realistic grant and rvalid timing in simulation and on FPGA.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, instruction word width
- MEM_WORDS, 1024, array depth in words; power of two, ≥2
- GNT_LATENCY, 0, minimum cycles `instr_req` is high before `instr_grant`; 0..15
- RVALID_LATENCY, 1, cycles from grant to rvalid for each request; 1..15
- DEPTH, 2, max outstanding (granted, unanswered) requests; 1..8
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- instr_req  input  1  fetch request; held high until granted
- instr_addr  input  ADDR_WIDTH  byte address; stable while `instr_req` is high
- instr_grant  output  1  request accepted this cycle
- instr_rvalid  output  1  `instr_rdata` valid this cycle; one pulse per granted request
- instr_rdata  output  DATA_WIDTH  instruction word
- load_we  input  1  preload write strobe
- load_addr  input  $clog2(MEM_WORDS)  preload word index
- load_data  input  DATA_WIDTH  preload data
- outstanding  output  $clog2(DEPTH+1)  granted but unanswered count

## Operation
- Word index is `instr_addr[..:2]` modulo MEM_WORDS. Low two bits are ignored and addresses wrap without error.
- Grant FSM has two states:
  - G_IDLE: enter G_WAIT when `instr_req` is high.
  - G_WAIT: `wait_cnt` increments each cycle `instr_req` is high without a grant.
- `instr_grant = instr_req && wait_cnt >= GNT_LATENCY && outstanding < DEPTH`. This is combinational from registered state and `instr_req`.
  - With GNT_LATENCY=0, grant comes in the same cycle as the request.
- On grant:
  - `wait_cnt` clears and the FSM returns to G_IDLE.
  - The FSM restays in G_WAIT if `instr_req` is still high next cycle, i.e. a new request.
- On grant, push {`mem[index]`, age=0} into the response FIFO. Data is captured at grant time.
- Every FIFO entry's age increments each cycle, saturating at 15.
- `instr_rvalid` is 1 when the head entry's age ≥ RVALID_LATENCY-1, registered so rvalid lands exactly RVALID_LATENCY cycles after grant.
  - On rvalid the head pops and `instr_rdata` holds the head data.
- Responses are strictly in grant order. The requester cannot stall rvalid.
- `outstanding` = FIFO occupancy.
  - Simultaneous push and pop: occupancy unchanged.
  - Full (=DEPTH): grant is withheld even if `wait_cnt` is satisfied. A pop in the same cycle does not free the slot until the next cycle.
- Preload: `load_we` writes `mem[load_addr]` at the clock edge.
  - Same-cycle load and grant to the same word: the grant captures the old value.
  - `load_we` is legal at any time, including during `rst`.

## Timing
- Reset values: `instr_grant`=0 (forced low while `rst`), `instr_rvalid`=0, `instr_rdata`=0, `outstanding`=0. FSM in G_IDLE, `wait_cnt`=0.
- Reset mid-operation flushes the FIFO. Pending requests never receive rvalid. Array contents are preserved.
- `instr_rdata` holds its last value when `instr_rvalid`=0.
- Back-to-back throughput: one grant per cycle when GNT_LATENCY=0 and DEPTH ≥ RVALID_LATENCY+1.
- Fetch latency request→rvalid = GNT_LATENCY + RVALID_LATENCY cycles, with an empty FIFO and no stall.
- `instr_req` dropping before grant is a protocol violation. The responder clears `wait_cnt`, returns to G_IDLE, and records nothing.

## Configuration
- INSTR_MEM_STALL_EN:
  - Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on `rst`) advances every cycle. Grant is additionally suppressed in any cycle where LFSR bit 0 = 1, giving pseudo-random extra grant stalls.
  - Undefined: no LFSR, and grant timing is fully deterministic per the rules above.

## Test plan
- Preload mem[4]=32'h0000_0013. GNT_LATENCY=0, RVALID_LATENCY=1. Request addr 32'h10 at cycle 0 -> grant at cycle 0, rvalid with rdata 32'h0000_0013 at cycle 1.
- GNT_LATENCY=3, RVALID_LATENCY=2, single request -> grant 3 cycles after req rises, rvalid 2 cycles after grant, `outstanding` 1 then 0.
- DEPTH=2, RVALID_LATENCY=4, req held continuously -> two consecutive grants, third withheld until first rvalid pops, `outstanding` saturates at 2, rdata in address order.
- Request addr MEM_WORDS*4+8 -> returns mem[2] (wrap-around).
- Same-cycle `load_we` to mem[5]=32'hDEAD_BEEF and grant of addr 32'h14 -> rdata is the old mem[5]. A following fetch of the same word returns 32'hDEAD_BEEF.
- Assert `rst` one cycle after a grant with RVALID_LATENCY=3 -> no rvalid ever issued, outputs 0, `outstanding`=0. After reset, a new fetch of preloaded data returns correct contents.
